// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares a 2**ADDR_W x DATA_W data memory (two registered read ports, one
// write port) between two requesters:
//   requester A (index 0) = core load/store unit
//   requester B (index 1) = loader / debug port
//
// Each requester presents a command with a valid/ready handshake. A command
// is either a write (addr1 + wdata) or a dual read (addr1 + addr2). Grants
// are round-robin, so under continuous contention they alternate A,B,A,B.
// A read returns both words together with a one-cycle rsp_valid pulse to the
// requester that issued it.
//
// Operation sequence:
//   IDLE  : pick a requester, raise its ready, latch its command at the edge
//   ISSUE : drive the memory for exactly one cycle (mem_enable_o = 1)
//   WAIT  : reads only; memory data is valid, forward it and pulse rsp_valid
//
// Ports
//   clk_i                     rising-edge clock
//   rst_i                     synchronous active-high reset
//   a_/b_valid_i              requester has a command
//   a_/b_write_i              1 = write, 0 = dual read
//   a_/b_addr1_i              read address 1, or the write address
//   a_/b_addr2_i              read address 2 (unused for writes)
//   a_/b_wdata_i              write data
//   a_/b_ready_o              command accepted this cycle
//   a_/b_rsp_valid_o          one-cycle pulse: rsp_data1_o/rsp_data2_o valid
//   rsp_data1_o, rsp_data2_o  read data, shared by both requesters
//   mem_enable_o              memory enable
//   mem_read_writenot_o       1 = read, 0 = write
//   mem_read_address1_o/2_o   memory read addresses
//   mem_write_address_o       memory write address
//   mem_in_data_o             memory write data
//   mem_out_data1_i/2_i       memory read data (registered by the memory at
//                             the ISSUE edge)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // requester A
   input  logic              a_valid_i,
   input  logic              a_write_i,
   input  logic [ADDR_W-1:0] a_addr1_i,
   input  logic [ADDR_W-1:0] a_addr2_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_ready_o,
   output logic              a_rsp_valid_o,
   // requester B
   input  logic              b_valid_i,
   input  logic              b_write_i,
   input  logic [ADDR_W-1:0] b_addr1_i,
   input  logic [ADDR_W-1:0] b_addr2_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_ready_o,
   output logic              b_rsp_valid_o,
   // shared response data
   output logic [DATA_W-1:0] rsp_data1_o,
   output logic [DATA_W-1:0] rsp_data2_o,
   // memory side
   output logic              mem_enable_o,
   output logic              mem_read_writenot_o,
   output logic [ADDR_W-1:0] mem_read_address1_o,
   output logic [ADDR_W-1:0] mem_read_address2_o,
   output logic [ADDR_W-1:0] mem_write_address_o,
   output logic [DATA_W-1:0] mem_in_data_o,
   input  logic [DATA_W-1:0] mem_out_data1_i,
   input  logic [DATA_W-1:0] mem_out_data2_i
);

   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Requesters gathered into two-entry vectors so the selection logic can
   // index by grant id instead of duplicating per-requester muxes.
   logic [1:0]        req_valid;
   logic [1:0]        req_write;
   logic [ADDR_W-1:0] req_addr1 [2];
   logic [ADDR_W-1:0] req_addr2 [2];
   logic [DATA_W-1:0] req_wdata [2];

   assign req_valid    = {b_valid_i, a_valid_i};
   assign req_write    = {b_write_i, a_write_i};
   assign req_addr1[0] = a_addr1_i;
   assign req_addr1[1] = b_addr1_i;
   assign req_addr2[0] = a_addr2_i;
   assign req_addr2[1] = b_addr2_i;
   assign req_wdata[0] = a_wdata_i;
   assign req_wdata[1] = b_wdata_i;

   // Latched command and bookkeeping
   logic              last_grant_q;   // requester served most recently
   logic              gnt_q;          // requester owning the current operation
   logic              rwn_q;          // drives mem_read_writenot_o directly
   logic [ADDR_W-1:0] addr1_q;
   logic [ADDR_W-1:0] addr2_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rsp_data1_q;
   logic [DATA_W-1:0] rsp_data2_q;

   // Arbitration
   logic grant_valid;
   logic grant_id;
   logic accept;

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = GNT_A;
      if (req_valid[0] && req_valid[1]) begin
         // Contention: whoever was not served last time wins.
         grant_valid = 1'b1;
         grant_id    = (last_grant_q == GNT_A) ? GNT_B : GNT_A;
      end else if (req_valid[0]) begin
         grant_valid = 1'b1;
         grant_id    = GNT_A;
      end else if (req_valid[1]) begin
         grant_valid = 1'b1;
         grant_id    = GNT_B;
      end
   end

   // A reset cycle never accepts: the command would be discarded at the edge
   // anyway, so advertising ready would lie to the requester.
   assign accept = (state_q == ST_IDLE) && grant_valid && !rst_i;

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Writes complete at the issue edge; reads need one more cycle
            // for the registered memory output.
            state_d = rwn_q ? ST_WAIT : ST_IDLE;
         end
         ST_WAIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command latch, round-robin history and read-data holding registers.
   // The latched command feeds the memory pins directly, so mem_* only move
   // on acceptance and otherwise hold their last values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q <= GNT_B;   // A wins the first contest after reset
         gnt_q        <= GNT_A;
         rwn_q        <= 1'b0;
         addr1_q      <= '0;
         addr2_q      <= '0;
         wdata_q      <= '0;
         rsp_data1_q  <= '0;
         rsp_data2_q  <= '0;
      end else begin
         if (accept) begin
            gnt_q   <= grant_id;
            rwn_q   <= ~req_write[grant_id];
            addr1_q <= req_addr1[grant_id];
            addr2_q <= req_addr2[grant_id];
            wdata_q <= req_wdata[grant_id];
         end
         if (state_q == ST_ISSUE) begin
            last_grant_q <= gnt_q;
         end
         if (state_q == ST_WAIT) begin
            rsp_data1_q <= mem_out_data1_i;
            rsp_data2_q <= mem_out_data2_i;
         end
      end
   end

   // FSM: outputs
   logic [1:0] ready_vec;
   logic [1:0] rsp_vec;
   logic       mem_enable;
   logic       rsp_fire;

   always_comb begin
      // Reset aborts whatever is in flight: no memory access and no response
      // pulse in the reset cycle itself.
      mem_enable = (state_q == ST_ISSUE) && !rst_i;
      rsp_fire   = (state_q == ST_WAIT)  && !rst_i;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign ready_vec[gi] = accept   && (grant_id == 1'(gi));
         assign rsp_vec[gi]   = rsp_fire && (gnt_q    == 1'(gi));
      end
   endgenerate

   assign a_ready_o     = ready_vec[0];
   assign b_ready_o     = ready_vec[1];
   assign a_rsp_valid_o = rsp_vec[0];
   assign b_rsp_valid_o = rsp_vec[1];

   // In WAIT the memory output is forwarded straight through so data lines up
   // with rsp_valid; afterwards the captured copy holds it until the next read.
   assign rsp_data1_o = rsp_fire ? mem_out_data1_i : rsp_data1_q;
   assign rsp_data2_o = rsp_fire ? mem_out_data2_i : rsp_data2_q;

   assign mem_enable_o        = mem_enable;
   assign mem_read_writenot_o = rwn_q;
   assign mem_read_address1_o = addr1_q;
   assign mem_read_address2_o = addr2_q;
   assign mem_write_address_o = addr1_q;
   assign mem_in_data_o       = wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_valid, a_write, b_valid, b_write;
   logic [AW-1:0] a_addr1, a_addr2, b_addr1, b_addr2;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
   logic [DW-1:0] rsp_data1, rsp_data2;
   logic          mem_enable, mem_read_writenot;
   logic [AW-1:0] mem_read_address1, mem_read_address2, mem_write_address;
   logic [DW-1:0] mem_in_data;
   logic [DW-1:0] mem_out_data1, mem_out_data2;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .a_valid_i           (a_valid),
      .a_write_i           (a_write),
      .a_addr1_i           (a_addr1),
      .a_addr2_i           (a_addr2),
      .a_wdata_i           (a_wdata),
      .a_ready_o           (a_ready),
      .a_rsp_valid_o       (a_rsp_valid),
      .b_valid_i           (b_valid),
      .b_write_i           (b_write),
      .b_addr1_i           (b_addr1),
      .b_addr2_i           (b_addr2),
      .b_wdata_i           (b_wdata),
      .b_ready_o           (b_ready),
      .b_rsp_valid_o       (b_rsp_valid),
      .rsp_data1_o         (rsp_data1),
      .rsp_data2_o         (rsp_data2),
      .mem_enable_o        (mem_enable),
      .mem_read_writenot_o (mem_read_writenot),
      .mem_read_address1_o (mem_read_address1),
      .mem_read_address2_o (mem_read_address2),
      .mem_write_address_o (mem_write_address),
      .mem_in_data_o       (mem_in_data),
      .mem_out_data1_i     (mem_out_data1),
      .mem_out_data2_i     (mem_out_data2)
   );

   // Memory the arbiter drives: registered dual read, single write.
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (mem_enable) begin
         if (!mem_read_writenot) begin
            mem[mem_write_address] <= mem_in_data;
         end else begin
            mem_out_data1 <= mem[mem_read_address1];
            mem_out_data2 <= mem[mem_read_address2];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: a command occupies the memory for a fixed number of
   // cycles after acceptance (write: 1, read: 2); the winner of a contest is
   // whoever was not served last.
   int            m_busy;      // cycles elapsed since acceptance, 0 = free
   bit            m_last;      // 0 = A served last, 1 = B
   bit            m_who, m_wr;
   logic [AW-1:0] m_a1, m_a2;
   logic [DW-1:0] m_wd, m_rd1, m_rd2, e_d1, e_d2;
   bit            e_rwn;
   logic [DW-1:0] ref_mem [64];
   bit            grant_log [$];

   task automatic tick();
      bit ga, gb;
      @(negedge clk);
      ga = 1'b0;
      gb = 1'b0;
      if (m_busy == 0) begin
         if (a_valid && (!b_valid || m_last)) ga = 1'b1;
         else if (b_valid)                     gb = 1'b1;
      end
      if (rst) begin
         chk("a_ready_in_rst", a_ready, 0);
         chk("b_ready_in_rst", b_ready, 0);
         chk("a_rsp_in_rst", a_rsp_valid, 0);
         chk("b_rsp_in_rst", b_rsp_valid, 0);
      end else begin
         chk("a_ready", a_ready, ga);
         chk("b_ready", b_ready, gb);
         chk("ready_onehot", a_ready & b_ready, 0);
         chk("mem_enable", mem_enable, m_busy == 1);
         chk("rwn", mem_read_writenot, (m_busy == 1) ? !m_wr : e_rwn);
         if (m_busy == 1) begin
            if (m_wr) begin
               chk("waddr", mem_write_address, m_a1);
               chk("wdata", mem_in_data, m_wd);
            end else begin
               chk("raddr1", mem_read_address1, m_a1);
               chk("raddr2", mem_read_address2, m_a2);
            end
         end
         chk("a_rsp_valid", a_rsp_valid, (m_busy == 2) && !m_who);
         chk("b_rsp_valid", b_rsp_valid, (m_busy == 2) && m_who);
         chk("rsp_data1", rsp_data1, (m_busy == 2) ? m_rd1 : e_d1);
         chk("rsp_data2", rsp_data2, (m_busy == 2) ? m_rd2 : e_d2);
      end
      @(posedge clk);
      if (rst) begin
         m_busy = 0;
         m_last = 1'b1;
         e_rwn  = 1'b0;
         e_d1   = '0;
         e_d2   = '0;
      end else if (m_busy == 0) begin
         if (ga || gb) begin
            m_who = gb;
            m_wr  = gb ? b_write : a_write;
            m_a1  = gb ? b_addr1 : a_addr1;
            m_a2  = gb ? b_addr2 : a_addr2;
            m_wd  = gb ? b_wdata : a_wdata;
            grant_log.push_back(gb);
            m_busy = 1;
         end
      end else if (m_busy == 1) begin
         m_last = m_who;
         e_rwn  = !m_wr;
         if (m_wr) begin
            ref_mem[m_a1] = m_wd;
            m_busy = 0;
         end else begin
            m_rd1  = ref_mem[m_a1];
            m_rd2  = ref_mem[m_a2];
            m_busy = 2;
         end
      end else begin
         e_d1   = m_rd1;
         e_d2   = m_rd2;
         m_busy = 0;
      end
      #1;
   endtask

   task automatic drive_a(input bit v, input bit w, input logic [AW-1:0] x1,
                          input logic [AW-1:0] x2, input logic [DW-1:0] d);
      a_valid = v; a_write = w; a_addr1 = x1; a_addr2 = x2; a_wdata = d;
   endtask

   task automatic drive_b(input bit v, input bit w, input logic [AW-1:0] x1,
                          input logic [AW-1:0] x2, input logic [DW-1:0] d);
      b_valid = v; b_write = w; b_addr1 = x1; b_addr2 = x2; b_wdata = d;
   endtask

   // Everything the arbiter drives must read zero just after a reset.
   task automatic zero_check(input string tag);
      @(negedge clk);
      chk({tag, "_a_ready"}, a_ready, 0);
      chk({tag, "_b_ready"}, b_ready, 0);
      chk({tag, "_a_rsp"}, a_rsp_valid, 0);
      chk({tag, "_b_rsp"}, b_rsp_valid, 0);
      chk({tag, "_rsp_data1"}, rsp_data1, 0);
      chk({tag, "_rsp_data2"}, rsp_data2, 0);
      chk({tag, "_mem_enable"}, mem_enable, 0);
      chk({tag, "_rwn"}, mem_read_writenot, 0);
      chk({tag, "_raddr1"}, mem_read_address1, 0);
      chk({tag, "_raddr2"}, mem_read_address2, 0);
      chk({tag, "_waddr"}, mem_write_address, 0);
      chk({tag, "_in_data"}, mem_in_data, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit first;
      int n_grants;
      int cnt;
      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      mem_out_data1 = '0;
      mem_out_data2 = '0;
      m_busy = 0; m_last = 1'b1; m_who = 1'b0; m_wr = 1'b0;
      m_a1 = '0; m_a2 = '0; m_wd = '0; m_rd1 = '0; m_rd2 = '0;
      e_rwn = 1'b0; e_d1 = '0; e_d2 = '0;
      drive_a(0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      zero_check("reset");

      // A write 5 <- 0xA5
      drive_a(1, 1, 6'd5, 6'd0, 8'hA5);
      tick();
      drive_a(0, 0, 0, 0, 0);
      tick();
      tick();

      // A dual read 5,0
      drive_a(1, 0, 6'd5, 6'd0, 8'h00);
      tick();
      drive_a(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      chk("held_rsp_data1", rsp_data1, 8'hA5);

      // Continuous contention with reads: grants must alternate
      grant_log.delete();
      first = !m_last;
      for (int i = 0; i < 18; i++) begin
         drive_a(1, 0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 8'h00);
         drive_b(1, 0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 8'h00);
         tick();
      end
      drive_a(0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      n_grants = grant_log.size();
      chk("contention_grants", n_grants, 6);
      for (int i = 0; i < n_grants; i++) begin
         chk("alternation", grant_log[i], first ^ i[0]);
      end

      // B writes 63 <- 0xFF, then A reads 63,63
      drive_b(1, 1, 6'd63, 6'd0, 8'hFF);
      tick();
      drive_b(0, 0, 0, 0, 0);
      tick();
      drive_a(1, 0, 6'd63, 6'd63, 8'h00);
      tick();
      drive_a(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      chk("read63_data1", rsp_data1, 8'hFF);
      chk("read63_data2", rsp_data2, 8'hFF);

      // Reset during WAIT of an A read
      drive_a(1, 0, 6'd5, 6'd63, 8'h00);
      tick();
      drive_a(0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      zero_check("abort");
      drive_a(1, 1, 6'd7, 6'd0, 8'h3C);
      drive_b(1, 1, 6'd8, 6'd0, 8'h11);
      @(negedge clk);
      chk("post_rst_a_first", a_ready, 1);
      chk("post_rst_b_waits", b_ready, 0);
      @(posedge clk);
      #1;
      // keep model in step: redo the accepted cycle through the model
      m_who = 1'b0; m_wr = 1'b1; m_a1 = 6'd7; m_a2 = 6'd0; m_wd = 8'h3C;
      grant_log.push_back(1'b0);
      m_busy = 1;
      drive_a(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      drive_b(0, 0, 0, 0, 0);
      tick();

      // a_valid pulsed only during ISSUE must never be granted
      drive_a(1, 1, 6'd10, 6'd0, 8'h55);
      tick();
      drive_a(1, 0, 6'd11, 6'd12, 8'h00);
      tick();
      drive_a(0, 0, 0, 0, 0);
      tick();
      tick();

      // Randomised traffic, occasional reset
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         drive_a($urandom_range(0, 1), $urandom_range(0, 1),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 8'($urandom));
         drive_b($urandom_range(0, 1), $urandom_range(0, 1),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 8'($urandom));
         tick();
         if (a_rsp_valid || b_rsp_valid) cnt++;
      end
      rst = 1'b0;
      drive_a(0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
